// File: rtl/pipe_register_if.sv
// Valid/ready channel pair for the elastic pipeline register: the producer
// side (in_*) and the consumer side (out_*) of one word stream.
interface pipe_register_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // master: the environment around the pipe (producer + consumer)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // slave: the pipe itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_register.sv
// Elastic DEPTH-stage valid/ready pipeline register with bubble collapsing,
// back-pressure and synchronous flush. Optional occupancy count: PIPE_REGISTER_COUNT_EN.

// One pipeline slot: a valid bit plus the word it guards.
module pipe_register_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (flush) begin
      // data is deliberately left in place; only the valid bit is cleared
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
      dat <= din;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end
endmodule

module pipe_register #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  pipe_register_if.slave                bus
`ifdef PIPE_REGISTER_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]    count
`endif
);
  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            load;
  logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] din;
  logic                        in_rdy;
  logic                        acc;

  // A stage advances when it holds a word and the slot ahead is empty or
  // itself advancing; resolved from the output end backwards.
  always_comb begin
    logic a;
    adv = '0;
    a = vld_pipe[DEPTH-1] & bus.out_ready;
    adv[DEPTH-1] = a;
    for (int i = DEPTH-2; i >= 0; i--) begin
      a = vld_pipe[i] & (~vld_pipe[i+1] | a);
      adv[i] = a;
    end
  end

  // Raw rst gates ready so nothing is accepted while reset is held.
  assign in_rdy = rst & ~flush & (~vld_pipe[0] | adv[0]);
  assign acc    = bus.in_valid & in_rdy;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
        assign load[g] = acc;
        assign din[g]  = bus.in_data;
      end else begin : g_body
        assign load[g] = adv[g-1];
        assign din[g]  = dat_pipe[g-1];
      end

      pipe_register_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .load  (load[g]),
        .drain (adv[g]),
        .din   (din[g]),
        .vld   (vld_pipe[g]),
        .dat   (dat_pipe[g])
      );
    end
  endgenerate

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_pipe[DEPTH-1];
  assign bus.out_data  = dat_pipe[DEPTH-1];

`ifdef PIPE_REGISTER_COUNT_EN
  localparam int CW = $clog2(DEPTH+1);
  logic pop;
  assign pop = vld_pipe[DEPTH-1] & bus.out_ready;

  // Tracks popcount(vld_pipe) incrementally; push+pop in one cycle nets out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             count <= '0;
    else if (flush)       count <= '0;
    else if (acc & ~pop)  count <= count + CW'(1);
    else if (pop & ~acc)  count <= count - CW'(1);
  end
`endif
endmodule

// File: tb/tb_pipe_register.sv
// Self-checking bench for pipe_register: directed vector table, hand-written
// corner sequences, then randomized traffic against a word-position model.
module tb_pipe_register;
  localparam int W  = 8;
  localparam int D  = 3;
  localparam int CW = $clog2(D+1);

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  pipe_register_if #(.WIDTH(W)) bus();
`ifdef PIPE_REGISTER_COUNT_EN
  logic [CW-1:0] count;
`endif

  pipe_register #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
`ifdef PIPE_REGISTER_COUNT_EN
    ,
    .count (count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         orr;
    logic         fl;
    logic         ir;
    logic         ov;
    logic [W-1:0] od;
    int           cnt;
  } vec_t;

  // Model: each live word remembers which stage it sits in.
  typedef struct {
    logic [W-1:0] d;
    int           p;
  } word_t;

  word_t        q[$];
  int           np[$];
  bit           popping;
  logic         exp_ir;
  logic [W-1:0] top_d;

  function automatic vec_t row(logic iv, logic [W-1:0] d, logic orr, logic fl,
                               logic ir, logic ov, logic [W-1:0] od, int cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.orr = orr; v.fl = fl;
    v.ir = ir; v.ov = ov; v.od = od; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic orr, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = orr;
    flush         = fl;
  endtask

  task automatic chk_out(input string tag, input logic ir, input logic ov,
                         input logic [W-1:0] od, input int cnt);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(od));
`ifdef PIPE_REGISTER_COUNT_EN
    chk({tag, ".count"},     32'(count),         32'(cnt));
`else
    if (cnt < 0) $display("bad count request %0d", cnt);
`endif
  endtask

  // Apply one cycle of stimulus, check before the edge, advance past it.
  task automatic run_vec(input string tag, input vec_t v);
    drive(v.iv, v.d, v.orr, v.fl);
    @(negedge clk);
    chk_out(tag, v.ir, v.ov, v.od, v.cnt);
    @(posedge clk);
    #1;
  endtask

  // Where each word lands after this edge: one stage forward, but never into
  // or past the stage its predecessor will occupy.
  task automatic model_eval(input logic orr, input logic fl, input logic r);
    int lim;
    lim = D;
    np.delete();
    popping = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0 && q[i].p == D-1 && orr) begin
        popping = 1;
        np.push_back(D);
      end else begin
        int n;
        n = q[i].p + 1;
        if (n > lim - 1) n = lim - 1;
        np.push_back(n);
        lim = n;
      end
    end
    exp_ir = r && !fl && (lim >= 1);
  endtask

  task automatic model_commit(input logic iv, input logic [W-1:0] d, input logic fl);
    word_t t;
    if (fl) begin
      q.delete();
      return;
    end
    for (int i = 0; i < q.size(); i++) begin
      t = q[i];
      if (np[i] == D-1 && t.p != D-1) top_d = t.d;
      t.p = np[i];
      q[i] = t;
    end
    if (popping) void'(q.pop_front());
    if (iv && exp_ir) begin
      t.d = d;
      t.p = 0;
      q.push_back(t);
      if (D == 1) top_d = d;
    end
  endtask

  vec_t tbl[15];

  initial begin
    logic         iv, orr, fl, hold;
    logic [W-1:0] dd;

    tbl[0]  = row(1, 8'h11, 1, 0,  1, 0, 8'h00, 0);
    tbl[1]  = row(0, 8'h00, 1, 0,  1, 0, 8'h00, 1);
    tbl[2]  = row(0, 8'h00, 1, 0,  1, 0, 8'h00, 1);
    tbl[3]  = row(0, 8'h00, 1, 0,  1, 1, 8'h11, 1);
    tbl[4]  = row(0, 8'h00, 1, 0,  1, 0, 8'h11, 0);
    tbl[5]  = row(1, 8'h21, 0, 0,  1, 0, 8'h11, 0);
    tbl[6]  = row(1, 8'h22, 0, 0,  1, 0, 8'h11, 1);
    tbl[7]  = row(1, 8'h23, 0, 0,  1, 0, 8'h11, 2);
    tbl[8]  = row(1, 8'h24, 0, 0,  0, 1, 8'h21, 3);
    tbl[9]  = row(1, 8'h24, 0, 0,  0, 1, 8'h21, 3);
    tbl[10] = row(1, 8'h24, 1, 0,  1, 1, 8'h21, 3);
    tbl[11] = row(0, 8'h00, 1, 0,  1, 1, 8'h22, 3);
    tbl[12] = row(0, 8'h00, 1, 0,  1, 1, 8'h23, 2);
    tbl[13] = row(0, 8'h00, 1, 0,  1, 1, 8'h24, 1);
    tbl[14] = row(0, 8'h00, 1, 0,  1, 0, 8'h24, 0);

    // reset held with a word offered
    drive(1, 8'hAA, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_out("reset", 0, 0, 8'h00, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 8'h00, 1, 0);
    @(negedge clk);
    chk_out("reset_release", 1, 0, 8'h00, 0);
    @(posedge clk);
    #1;

    // latency, back-pressure, full push+pop
    for (int k = 0; k < 15; k++) run_vec($sformatf("vec%0d", k), tbl[k]);

    // back-to-back stream 01..08
    for (int k = 0; k < 12; k++) begin
      drive(k < 8, 8'(k + 1), 1, 0);
      @(negedge clk);
      chk($sformatf("stream%0d.in_ready", k), 32'(bus.in_ready), 32'd1);
      chk($sformatf("stream%0d.out_valid", k), 32'(bus.out_valid), 32'(k >= 3 && k < 11));
      if (k >= 3 && k < 11)
        chk($sformatf("stream%0d.out_data", k), 32'(bus.out_data), 32'(k - 2));
      @(posedge clk);
      #1;
    end

    // bubble collapse under back-pressure
    run_vec("bub0", row(1, 8'h31, 0, 0,  1, 0, 8'h08, 0));
    run_vec("bub1", row(0, 8'h00, 0, 0,  1, 0, 8'h08, 1));
    run_vec("bub2", row(0, 8'h00, 0, 0,  1, 0, 8'h08, 1));
    run_vec("bub3", row(1, 8'h32, 0, 0,  1, 1, 8'h31, 1));
    run_vec("bub4", row(0, 8'h00, 0, 0,  1, 1, 8'h31, 2));
    run_vec("bub5", row(0, 8'h00, 0, 0,  1, 1, 8'h31, 2));
    run_vec("bub6", row(0, 8'h00, 1, 0,  1, 1, 8'h31, 2));
    run_vec("bub7", row(0, 8'h00, 1, 0,  1, 1, 8'h32, 1));
    run_vec("bub8", row(0, 8'h00, 1, 0,  1, 0, 8'h32, 0));

    // flush with two words resident and a word offered
    run_vec("fl0", row(1, 8'h51, 0, 0,  1, 0, 8'h32, 0));
    run_vec("fl1", row(1, 8'h52, 0, 0,  1, 0, 8'h32, 1));
    run_vec("fl2", row(0, 8'h00, 0, 0,  1, 0, 8'h32, 2));
    run_vec("fl3", row(1, 8'h41, 0, 1,  0, 1, 8'h51, 2));
    run_vec("fl4", row(0, 8'h00, 1, 0,  1, 0, 8'h51, 0));
    run_vec("fl5", row(0, 8'h00, 1, 0,  1, 0, 8'h51, 0));
    run_vec("fl6", row(0, 8'h00, 1, 0,  1, 0, 8'h51, 0));

    // asynchronous reset mid-cycle with a word at the output
    run_vec("ar0", row(1, 8'h61, 0, 0,  1, 0, 8'h51, 0));
    run_vec("ar1", row(0, 8'h00, 0, 0,  1, 0, 8'h51, 1));
    run_vec("ar2", row(0, 8'h00, 0, 0,  1, 0, 8'h51, 1));
    drive(0, 8'h00, 0, 0);
    @(negedge clk);
    chk_out("ar3", 1, 1, 8'h61, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_out("ar_async", 0, 0, 8'h00, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_vec("ar4", row(0, 8'h00, 1, 0,  1, 0, 8'h00, 0));

    // randomized traffic against the model
    q.delete();
    top_d = '0;
    hold  = 1'b0;
    dd    = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        iv = ($urandom % 10) < 6;
        dd = W'($urandom);
      end
      orr = ($urandom % 10) < 6;
      fl  = ($urandom % 40) == 0;
      rst = ($urandom % 150) != 0;
      drive(iv, dd, orr, fl);
      if (!rst) begin
        q.delete();
        top_d = '0;
      end
      @(negedge clk);
      model_eval(orr, fl, rst);
      chk_out($sformatf("rnd%0d", c), exp_ir,
              q.size() > 0 && q[0].p == D-1, top_d, q.size());
      hold = iv && !exp_ir && rst;
      @(posedge clk);
      if (rst) model_commit(iv, dd, fl);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_register.md
Name: pipe_register

Overview:
- Parametrised, elastic pipeline register for WIDTH-bit words, DEPTH stages deep, with valid/ready handshake on both sides.
- Successor to the plain load-enable register. Adds multi-stage depth, per-stage bubble collapsing, back-pressure and a synchronous flush.
- Used between datapath blocks where producer and consumer stall independently, e.g. between a compute unit and its result sink.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 3, number of register stages (>=1); also the minimum input-to-output latency in cycles

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  reset, asynchronous, active-low (rst==0 resets immediately, independent of clk)
- flush  input  1  synchronous clear of all stage valid bits
- in_valid  input  1  producer presents in_data this cycle
- in_data  input  WIDTH  input word
- in_ready  output  1  block accepts in_data this cycle
- out_valid  output  1  out_data holds a valid word
- out_data  output  WIDTH  output word, from stage DEPTH-1
- out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- State per stage i (0..DEPTH-1):
  - v[i]: valid bit
  - d[i]: WIDTH-bit data word
- Reset (rst==0, async):
  - all v[i]=0 and all d[i]=0
  - therefore out_valid=0, out_data=0 and in_ready=0 while rst is low
- Combinational advance chain:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready
  - adv[i] = v[i] & (~v[i+1] | adv[i+1])
  - in_ready = rst & ~flush & (~v[0] | adv[0]), where rst is the raw reset input
- Accept: acc = in_valid & in_ready.
- Posedge update, no flush:
  - Stage 0: if acc, v[0]<=1 and d[0]<=in_data; else if adv[0], v[0]<=0.
  - Stage i>0: if adv[i-1], v[i]<=1 and d[i]<=d[i-1]; else if adv[i], v[i]<=0.
  - Data of an invalid stage holds its last value; it is not re-zeroed.
- Bubbles collapse: a word moves forward whenever the next stage is empty or draining, even while out_ready=0.
- Latency: a word accepted at cycle N appears on out_valid at cycle N+DEPTH when there is no downstream stall.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Capacity: DEPTH words. When all stages are valid and out_ready=0:
  - in_ready=0
  - contents and out_data hold stable
- Full with out_ready=1: in_ready=1 in the same cycle (combinational ready pass-through), so simultaneous pop and push keep the pipe full.
- Flush (flush==1 at posedge):
  - all v[i]<=0
  - in_ready=0 during the flush cycle, so nothing is accepted
  - d[i] are unchanged
  - out_valid may be 1 during the flush cycle; if out_ready=1 in that cycle the consumer takes the word (that transfer counts)
- Flush and rst low together: rst dominates.
- Handshake rules:
  - Producer must hold in_data stable while in_valid=1 and in_ready=0.
  - Block guarantees out_data stable while out_valid=1 and out_ready=0.
- Reset deasserted mid-operation: pipe restarts empty; no word survives reset.

Optional Feature:
- Macro: PIPE_REGISTER_COUNT_EN
- Defined:
  - adds output port count, width $clog2(DEPTH+1), equal to the number of set v[i] bits
  - registered: count increments on acc without pop and decrements on pop (out_valid & out_ready) without acc
  - reset and flush set it to 0
  - at no time does count exceed DEPTH
- Undefined: count port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with in_valid=1 and in_data=8'hAA -> out_valid=0, out_data=8'h00, in_ready=0; after rst=1, in_ready=1 on the next cycle.
- Latency: WIDTH=8, DEPTH=3, out_ready=1; push 8'h11 at cycle 0 -> out_valid=1, out_data=8'h11 at cycle 3; stream 8'h01..8'h08 back-to-back -> output in order with no gaps.
- Back-pressure: out_ready=0, push 8'h21, 8'h22, 8'h23 -> in_ready=0 after the third accept; out_data=8'h21 held stable; 4th word 8'h24 not accepted.
- Simultaneous push/pop when full: full pipe, out_ready=1 and in_valid=1 with 8'h24 -> in_ready=1, 8'h21 popped, 8'h24 accepted; count stays 3 if PIPE_REGISTER_COUNT_EN is defined.
- Bubble collapse: push 8'h31, idle 2 cycles, push 8'h32, with out_ready=0 -> both words occupy stages 2 and 1; releasing out_ready yields 8'h31 then 8'h32 on consecutive cycles.
- Flush: pipe holding 2 words, flush=1 with in_valid=1 and 8'h41 -> in_ready=0; next cycle out_valid=0; 8'h41 never appears at out_data; count=0 if PIPE_REGISTER_COUNT_EN is defined.
